// File: rtl/sssp_core_dispatch_if.sv
// Dequeue handshake plus the shared launch/completion bus between the dispatcher and its cores.
interface sssp_core_dispatch_if #(
    parameter int N_CORES  = 4,
    parameter int TQ_WIDTH = 64
);
    logic                task_in_valid;
    logic                task_in_ready;
    logic [TQ_WIDTH-1:0] task_in_data;
    logic [TQ_WIDTH-1:0] core_task;
    logic [N_CORES-1:0]  core_ap_start;
    logic [N_CORES-1:0]  core_ap_ready;
    logic [N_CORES-1:0]  core_ap_done;

    modport master (
        input  task_in_valid, task_in_data, core_ap_ready, core_ap_done,
        output task_in_ready, core_task, core_ap_start
    );

    modport slave (
        output task_in_valid, task_in_data, core_ap_ready, core_ap_done,
        input  task_in_ready, core_task, core_ap_start
    );
endinterface

// File: rtl/sssp_core_dispatch.sv
// Single-entry task buffer feeding N cores round-robin, with per-core busy tracking,
// drain control, quiesce status and dispatched/completed debug counters.
module sssp_core_dispatch #(
    parameter int N_CORES  = 4,
    parameter int CNT_W    = 32,
    parameter int TQ_WIDTH = 64
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    sssp_core_dispatch_if.master bus,
    input  logic                 drain,
    output logic [N_CORES-1:0]   busy,
    output logic                 quiesced,
    output logic [CNT_W-1:0]     cnt_dispatched,
    output logic [CNT_W-1:0]     cnt_completed,
    output logic                 err_spurious_done
);
    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic                buf_valid;
    logic [TQ_WIDTH-1:0] buf_data;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    rr_next;
    logic [N_CORES-1:0]  eligible;
    logic [N_CORES-1:0]  grant_oh;
    logic [N_CORES-1:0]  done_ok;
    logic [N_CORES-1:0]  done_bad;
    logic                found;
    logic                launch;
    logic                load;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_CORES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CORES; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    assign eligible = ~busy & bus.core_ap_ready;
    assign done_ok  = bus.core_ap_done & busy;
    assign done_bad = bus.core_ap_done & ~busy;

    // First eligible core at or above rr_ptr, wrapping modulo N_CORES.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (!found && eligible[idx[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (launch) grant_oh[grant_idx] = 1'b1;
    end

    assign launch  = buf_valid & ~drain & found;
    assign rr_next = (grant_idx == PTR_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;

    // Reset gating keeps the dequeue port from handshaking while held in reset.
    assign bus.task_in_ready = ap_rst_n & (~buf_valid | launch);
    assign load              = bus.task_in_valid & bus.task_in_ready;
    assign bus.core_ap_start = grant_oh;
    assign bus.core_task     = buf_valid ? buf_data : '0;
    assign quiesced          = ~buf_valid & (busy == '0);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            buf_valid         <= 1'b0;
            busy              <= '0;
            rr_ptr            <= '0;
            cnt_dispatched    <= '0;
            cnt_completed     <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            if (load)        buf_valid <= 1'b1;
            else if (launch) buf_valid <= 1'b0;
            busy <= (busy & ~done_ok) | grant_oh;
            if (launch) begin
                rr_ptr         <= rr_next;
                cnt_dispatched <= cnt_dispatched + CNT_W'(1);
            end
            cnt_completed <= cnt_completed + popcount(done_ok);
            if (|done_bad) err_spurious_done <= 1'b1;
        end
    end

    // Task payload carries no reset; buf_valid qualifies it everywhere.
    always_ff @(posedge ap_clk) begin
        if (load) buf_data <= bus.task_in_data;
    end
endmodule

// File: tb/tb_sssp_core_dispatch.sv
// Directed scenarios for sssp_core_dispatch; launches are checked against a queue of expected (core, task) pairs.
module tb_sssp_core_dispatch;
    localparam int N  = 4;
    localparam int TW = 64;

    typedef struct {
        int            core;
        logic [TW-1:0] data;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         drain;
    logic [N-1:0] busy;
    logic         quiesced;
    logic [3:0]   cnt_disp;
    logic [3:0]   cnt_comp;
    logic         err;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    sssp_core_dispatch_if #(.N_CORES(N), .TQ_WIDTH(TW)) bus_if ();

    sssp_core_dispatch #(.N_CORES(N), .CNT_W(4), .TQ_WIDTH(TW)) dut (
        .ap_clk            (clk),
        .ap_rst_n          (rst_n),
        .bus               (bus_if),
        .drain             (drain),
        .busy              (busy),
        .quiesced          (quiesced),
        .cnt_dispatched    (cnt_disp),
        .cnt_completed     (cnt_comp),
        .err_spurious_done (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [TW-1:0] mk(int hv, int tv);
        return {32'hC0DE0000 + 32'(hv * 3 + tv), 8'h01, 8'(hv), 16'(tv)};
    endfunction

    // Launch monitor: every start pulse must match the oldest expected launch.
    always @(negedge clk) begin
        if (rst_n && (bus_if.core_ap_start != '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_launch start=%b task=%h", bus_if.core_ap_start, bus_if.core_task);
            end else begin
                exp_t e;
                logic [N-1:0] oh;
                e  = exp_q.pop_front();
                oh = 4'b0001 << e.core;
                if (bus_if.core_ap_start !== oh || bus_if.core_task !== e.data) begin
                    failures++;
                    $display("FAIL launch start=%b task=%h exp_start=%b exp_task=%h",
                             bus_if.core_ap_start, bus_if.core_task, oh, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int core, logic [TW-1:0] d);
        exp_t e;
        e.core = core;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.task_in_valid = 1'b0;
        bus_if.task_in_data  = '0;
        bus_if.core_ap_ready = '1;
        bus_if.core_ap_done  = '0;
        drain = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus_if.task_in_valid = 1'b0;
        bus_if.task_in_data  = '0;
        bus_if.core_ap_ready = '1;
        bus_if.core_ap_done  = '0;
        drain = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 4'b0000 || bus_if.core_ap_start !== 4'b0000 || bus_if.task_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b start=%b ready=%b exp 0000/0000/0", busy, bus_if.core_ap_start, bus_if.task_in_ready);
        end
        checks++;
        if (bus_if.core_task !== '0 || cnt_disp !== 4'd0 || cnt_comp !== 4'd0 || err !== 1'b0 || quiesced !== 1'b1) begin
            failures++;
            $display("FAIL reset_status task=%h disp=%0d comp=%0d err=%b q=%b exp 0/0/0/0/1",
                     bus_if.core_task, cnt_disp, cnt_comp, err, quiesced);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [TW-1:0] d;
        do_reset();
        d = mk(5, 10);
        bus_if.task_in_valid = 1'b1;
        bus_if.task_in_data  = d;
        #1;
        checks++;
        if (bus_if.task_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b exp=1", bus_if.task_in_ready);
        end
        push(0, d);
        tick();
        bus_if.task_in_valid = 1'b0;
        #1;
        checks++;
        if (bus_if.core_ap_start !== 4'b0001 || bus_if.core_task !== d) begin
            failures++;
            $display("FAIL single_start start=%b task=%h exp 0001 %h", bus_if.core_ap_start, bus_if.core_task, d);
        end
        tick();
        checks++;
        if (busy !== 4'b0001 || cnt_disp !== 4'd1) begin
            failures++;
            $display("FAIL single_busy busy=%b disp=%0d exp 0001 1", busy, cnt_disp);
        end
        tick();
        tick();
        bus_if.core_ap_done = 4'b0001;
        tick();
        bus_if.core_ap_done = 4'b0000;
        #1;
        checks++;
        if (busy !== 4'b0000 || cnt_comp !== 4'd1 || quiesced !== 1'b1) begin
            failures++;
            $display("FAIL single_done busy=%b comp=%0d q=%b exp 0000 1 1", busy, cnt_comp, quiesced);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus_if.task_in_valid = 1'b1;
            bus_if.task_in_data  = mk(i, 20 + i);
            #1;
            checks++;
            if (bus_if.task_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rr_ready_%0d got=%b exp=1", i, bus_if.task_in_ready);
            end
            if (i >= 1) begin
                checks++;
                if (bus_if.core_ap_start !== (4'b0001 << (i - 1))) begin
                    failures++;
                    $display("FAIL rr_start_%0d got=%b exp=%b", i, bus_if.core_ap_start, 4'b0001 << (i - 1));
                end
            end
            if (i < 4) push(i, mk(i, 20 + i));
            tick();
        end
        bus_if.task_in_data = mk(5, 25);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (bus_if.core_ap_start !== 4'b0000 || bus_if.task_in_ready !== 1'b0 ||
                busy !== 4'b1111 || bus_if.core_task !== mk(4, 24)) begin
                failures++;
                $display("FAIL rr_full_%0d start=%b ready=%b busy=%b task=%h", c,
                         bus_if.core_ap_start, bus_if.task_in_ready, busy, bus_if.core_task);
            end
            tick();
        end
        bus_if.core_ap_ready = 4'b1011;
        bus_if.core_ap_done  = 4'b0100;
        tick();
        bus_if.core_ap_done = 4'b0000;
        #1;
        checks++;
        if (busy !== 4'b1011 || bus_if.core_ap_start !== 4'b0000 || bus_if.task_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rr_wait_ready busy=%b start=%b ready=%b exp 1011 0000 0", busy, bus_if.core_ap_start, bus_if.task_in_ready);
        end
        push(2, mk(4, 24));
        bus_if.core_ap_ready = 4'b1111;
        #1;
        checks++;
        if (bus_if.core_ap_start !== 4'b0100 || bus_if.task_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rr_release start=%b ready=%b exp 0100 1", bus_if.core_ap_start, bus_if.task_in_ready);
        end
        tick();
        bus_if.task_in_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 4'b1111 || quiesced !== 1'b0 || cnt_disp !== 4'd5 || cnt_comp !== 4'd1 ||
            bus_if.core_task !== mk(5, 25)) begin
            failures++;
            $display("FAIL rr_final busy=%b q=%b disp=%0d comp=%0d task=%h", busy, quiesced, cnt_disp, cnt_comp, bus_if.core_task);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rr_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_if.task_in_valid = 1'b1;
            bus_if.task_in_data  = mk(i, 40 + i);
            push(i, mk(i, 40 + i));
            tick();
        end
        bus_if.task_in_valid = 1'b0;
        bus_if.core_ap_done  = 4'b0010;
        #1;
        checks++;
        if (bus_if.core_ap_start !== 4'b1000 || cnt_disp !== 4'd3 || cnt_comp !== 4'd0) begin
            failures++;
            $display("FAIL simul_pre start=%b disp=%0d comp=%0d exp 1000 3 0", bus_if.core_ap_start, cnt_disp, cnt_comp);
        end
        tick();
        bus_if.core_ap_done = 4'b0000;
        #1;
        checks++;
        if (busy !== 4'b1101 || cnt_disp !== 4'd4 || cnt_comp !== 4'd1) begin
            failures++;
            $display("FAIL simul_launch_done busy=%b disp=%0d comp=%0d exp 1101 4 1", busy, cnt_disp, cnt_comp);
        end
        bus_if.core_ap_done = 4'b0101;
        tick();
        bus_if.core_ap_done = 4'b0000;
        #1;
        checks++;
        if (busy !== 4'b1000 || cnt_comp !== 4'd3) begin
            failures++;
            $display("FAIL simul_two_done busy=%b comp=%0d exp 1000 3", busy, cnt_comp);
        end
    endtask

    task automatic test_drain();
        do_reset();
        bus_if.task_in_valid = 1'b1;
        bus_if.task_in_data  = mk(0, 60);
        push(0, mk(0, 60));
        tick();
        bus_if.task_in_data = mk(1, 61);
        push(1, mk(1, 61));
        tick();
        bus_if.task_in_valid = 1'b0;
        tick();
        drain = 1'b1;
        bus_if.task_in_valid = 1'b1;
        bus_if.task_in_data  = mk(2, 62);
        #1;
        checks++;
        if (bus_if.task_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_accept ready=%b exp=1", bus_if.task_in_ready);
        end
        tick();
        bus_if.task_in_valid = 1'b0;
        #1;
        checks++;
        if (bus_if.core_ap_start !== 4'b0000 || bus_if.task_in_ready !== 1'b0 || busy !== 4'b0011) begin
            failures++;
            $display("FAIL drain_hold start=%b ready=%b busy=%b exp 0000 0 0011", bus_if.core_ap_start, bus_if.task_in_ready, busy);
        end
        bus_if.core_ap_done = 4'b0011;
        tick();
        bus_if.core_ap_done = 4'b0000;
        #1;
        checks++;
        if (busy !== 4'b0000 || quiesced !== 1'b0 || bus_if.core_ap_start !== 4'b0000 || cnt_comp !== 4'd2) begin
            failures++;
            $display("FAIL drain_buffered busy=%b q=%b start=%b comp=%0d exp 0000 0 0000 2", busy, quiesced, bus_if.core_ap_start, cnt_comp);
        end
        tick();
        push(2, mk(2, 62));
        drain = 1'b0;
        #1;
        checks++;
        if (bus_if.core_ap_start !== 4'b0100 || bus_if.core_task !== mk(2, 62)) begin
            failures++;
            $display("FAIL drain_release start=%b task=%h exp 0100 %h", bus_if.core_ap_start, bus_if.core_task, mk(2, 62));
        end
        tick();
        #1;
        checks++;
        if (busy !== 4'b0100 || quiesced !== 1'b0) begin
            failures++;
            $display("FAIL drain_inflight busy=%b q=%b exp 0100 0", busy, quiesced);
        end
        bus_if.core_ap_done = 4'b0100;
        tick();
        bus_if.core_ap_done = 4'b0000;
        #1;
        checks++;
        if (quiesced !== 1'b1 || cnt_disp !== 4'd3 || cnt_comp !== 4'd3) begin
            failures++;
            $display("FAIL drain_quiesced q=%b disp=%0d comp=%0d exp 1 3 3", quiesced, cnt_disp, cnt_comp);
        end
    endtask

    task automatic test_spurious_wrap();
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL spur_initial err=%b exp=0", err);
        end
        bus_if.core_ap_done = 4'b1000;
        tick();
        bus_if.core_ap_done = 4'b0000;
        #1;
        checks++;
        if (err !== 1'b1 || cnt_comp !== 4'd0 || cnt_disp !== 4'd0 || busy !== 4'b0000) begin
            failures++;
            $display("FAIL spur_done err=%b comp=%0d disp=%0d busy=%b exp 1 0 0 0000", err, cnt_comp, cnt_disp, busy);
        end
        for (int i = 0; i < 17; i++) begin
            bus_if.task_in_valid = 1'b1;
            bus_if.task_in_data  = mk(i, 100 + i);
            push(i % 4, mk(i, 100 + i));
            tick();
            bus_if.task_in_valid = 1'b0;
            tick();
            bus_if.core_ap_done = 4'b0001 << (i % 4);
            tick();
            bus_if.core_ap_done = 4'b0000;
        end
        #1;
        checks++;
        if (cnt_comp !== 4'd1 || cnt_disp !== 4'd1 || err !== 1'b1 || busy !== 4'b0000) begin
            failures++;
            $display("FAIL wrap comp=%0d disp=%0d err=%b busy=%b exp 1 1 1 0000", cnt_comp, cnt_disp, err, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_if.core_ap_ready = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            bus_if.task_in_valid = 1'b1;
            bus_if.task_in_data  = mk(i, 80 + i);
            if (i < 3) push(i, mk(i, 80 + i));
            tick();
        end
        bus_if.task_in_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 4'b0111 || bus_if.core_ap_start !== 4'b0000 || bus_if.task_in_ready !== 1'b0 || quiesced !== 1'b0) begin
            failures++;
            $display("FAIL arst_pre busy=%b start=%b ready=%b q=%b exp 0111 0000 0 0",
                     busy, bus_if.core_ap_start, bus_if.task_in_ready, quiesced);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 4'b0000 || bus_if.core_ap_start !== 4'b0000 || bus_if.task_in_ready !== 1'b0 ||
            bus_if.core_task !== '0 || quiesced !== 1'b1 || cnt_disp !== 4'd0) begin
            failures++;
            $display("FAIL arst_immediate busy=%b start=%b ready=%b task=%h q=%b disp=%0d",
                     busy, bus_if.core_ap_start, bus_if.task_in_ready, bus_if.core_task, quiesced, cnt_disp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL arst_pending got=%0d exp=0", exp_q.size());
        end
        tick();
        rst_n = 1'b1;
        bus_if.core_ap_ready = 4'b1111;
        bus_if.task_in_valid = 1'b1;
        bus_if.task_in_data  = mk(9, 90);
        #1;
        checks++;
        if (bus_if.task_in_ready !== 1'b1 || quiesced !== 1'b1) begin
            failures++;
            $display("FAIL arst_release ready=%b q=%b exp 1 1", bus_if.task_in_ready, quiesced);
        end
        push(0, mk(9, 90));
        tick();
        bus_if.task_in_valid = 1'b0;
        #1;
        checks++;
        if (bus_if.core_ap_start !== 4'b0001) begin
            failures++;
            $display("FAIL arst_next_core start=%b exp=0001", bus_if.core_ap_start);
        end
        tick();
        #1;
        checks++;
        if (busy !== 4'b0001 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL arst_busy busy=%b pending=%0d exp 0001 0", busy, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_drain();
        test_spurious_wrap();
        test_async_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
